// File: rtl/systolic_pkg.sv
// systolic_pkg: shared FSM states, default sizes and C index helper for the systolic matmul engine.
package systolic_pkg;
    typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DONE} state_t;
    localparam int N_DEF      = 3;
    localparam int DATA_W_DEF = 32;
    localparam int ACC_W_DEF  = 64;
    localparam int K_MAX_DEF  = 255;
    function automatic int c_idx(input int i, input int j, input int n = N_DEF);
        return i * n + j;
    endfunction
endpackage

// File: rtl/systolic_if.sv
// systolic_if: operand stream, result hand-off and control signals between host and engine.
interface systolic_if #(
    parameter int N      = 3,
    parameter int DATA_W = 32,
    parameter int ACC_W  = 64,
    parameter int KW     = 8
) ();
    logic                  start;
    logic [KW-1:0]         k_len;
    logic                  in_valid;
    logic                  in_ready;
    logic [N*DATA_W-1:0]   a_vec;
    logic [N*DATA_W-1:0]   b_vec;
    logic                  res_valid;
    logic                  res_ready;
    logic [N*N*ACC_W-1:0]  c_flat;
    logic                  busy;
    modport master (
        output start, k_len, in_valid, a_vec, b_vec, res_ready,
        input  in_ready, res_valid, c_flat, busy
    );
    modport slave (
        input  start, k_len, in_valid, a_vec, b_vec, res_ready,
        output in_ready, res_valid, c_flat, busy
    );
endinterface

// File: rtl/systolic_pe.sv
// systolic_pe: one MAC cell; passes a right and b down, accumulates a*b on each advance.
// SYSTOLIC_SIGNED_EN selects two's-complement operands, otherwise unsigned.
module systolic_pe #(
    parameter int DATA_W = 32,
    parameter int ACC_W  = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_clr,
    input  logic              i_adv,
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    output logic [DATA_W-1:0] o_a,
    output logic [DATA_W-1:0] o_b,
    output logic [ACC_W-1:0]  o_acc
);
    logic [DATA_W-1:0] r_a, r_b;
    logic [ACC_W-1:0]  r_acc, w_prod;
    logic              w_sa, w_sb;
`ifdef SYSTOLIC_SIGNED_EN
    assign w_sa = i_a[DATA_W-1];
    assign w_sb = i_b[DATA_W-1];
`else
    assign w_sa = 1'b0;
    assign w_sb = 1'b0;
`endif
    // Extending operands to ACC_W first makes the truncated product the correctly extended one.
    assign w_prod = {{(ACC_W-DATA_W){w_sa}}, i_a} * {{(ACC_W-DATA_W){w_sb}}, i_b};
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a   <= '0;
            r_b   <= '0;
            r_acc <= '0;
        end else if (i_clr) begin
            r_a   <= '0;
            r_b   <= '0;
            r_acc <= '0;
        end else if (i_adv) begin
            r_a   <= i_a;
            r_b   <= i_b;
            r_acc <= r_acc + w_prod;
        end
    end
    assign o_a   = r_a;
    assign o_b   = r_b;
    assign o_acc = r_acc;
endmodule

// File: rtl/systolic_matmul_engine.sv
// systolic_matmul_engine: N x N output-stationary systolic C = A*B with internal skew and control FSM.
// Build with SYSTOLIC_SIGNED_EN for two's-complement operands (unsigned otherwise).
module systolic_matmul_engine
    import systolic_pkg::*;
#(
    parameter int N      = N_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int ACC_W  = ACC_W_DEF,
    parameter int K_MAX  = K_MAX_DEF,
    localparam int KW    = $clog2(K_MAX + 1)
) (
    input logic       clk,
    input logic       rst_n,
    systolic_if.slave bus
);
    localparam int FW = $clog2(2 * N - 1);
    localparam logic [FW-1:0] FLUSH_LAST = FW'(2 * N - 3);
    state_t        r_state;
    logic [KW-1:0] r_k, r_beat;
    logic [FW-1:0] r_flush;
    logic          r_in_ready, r_res_valid, r_busy;
    logic          w_clr, w_adv, w_load;
    logic [DATA_W-1:0] w_a [N][N+1];
    logic [DATA_W-1:0] w_b [N+1][N];
    logic [ACC_W-1:0]  w_acc [N][N];
    assign w_load = r_state == LOAD;
    assign w_clr  = r_state == IDLE && bus.start;
    assign w_adv  = (w_load && bus.in_valid) || r_state == FLUSH;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_k         <= '0;
            r_beat      <= '0;
            r_flush     <= '0;
            r_in_ready  <= 1'b0;
            r_res_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (bus.start) begin
                    r_k         <= bus.k_len;
                    r_beat      <= '0;
                    r_flush     <= '0;
                    r_busy      <= 1'b1;
                    r_state     <= bus.k_len == '0 ? DONE : LOAD;
                    r_in_ready  <= bus.k_len != '0;
                    r_res_valid <= bus.k_len == '0;
                end
                LOAD: if (bus.in_valid) begin
                    r_beat <= r_beat + KW'(1);
                    if (r_beat == r_k - KW'(1)) begin
                        r_state    <= FLUSH;
                        r_in_ready <= 1'b0;
                    end
                end
                FLUSH: begin
                    r_flush <= r_flush + FW'(1);
                    if (r_flush == FLUSH_LAST) begin
                        r_state     <= DONE;
                        r_res_valid <= 1'b1;
                    end
                end
                DONE: if (bus.res_ready) begin
                    r_state     <= IDLE;
                    r_res_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
    assign bus.in_ready  = r_in_ready;
    assign bus.res_valid = r_res_valid;
    assign bus.busy      = r_busy;
    // Row i of A and column i of B enter through i delay stages; zeros are fed once loading ends.
    for (genvar i = 0; i < N; i++) begin : g_skew
        logic [DATA_W-1:0] w_a_src, w_b_src;
        assign w_a_src = w_load ? bus.a_vec[i*DATA_W +: DATA_W] : '0;
        assign w_b_src = w_load ? bus.b_vec[i*DATA_W +: DATA_W] : '0;
        if (i == 0) begin : g_direct
            assign w_a[0][0] = w_a_src;
            assign w_b[0][0] = w_b_src;
        end else begin : g_delay
            logic [DATA_W-1:0] r_da [i];
            logic [DATA_W-1:0] r_db [i];
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n || w_clr) begin
                    for (int t = 0; t < i; t++) begin
                        r_da[t] <= '0;
                        r_db[t] <= '0;
                    end
                end else if (w_adv) begin
                    r_da[0] <= w_a_src;
                    r_db[0] <= w_b_src;
                    for (int t = 1; t < i; t++) begin
                        r_da[t] <= r_da[t-1];
                        r_db[t] <= r_db[t-1];
                    end
                end
            end
            assign w_a[i][0] = r_da[i-1];
            assign w_b[0][i] = r_db[i-1];
        end
    end
    for (genvar i = 0; i < N; i++) begin : g_row
        for (genvar j = 0; j < N; j++) begin : g_col
            systolic_pe #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_pe (
                .clk   (clk),
                .rst_n (rst_n),
                .i_clr (w_clr),
                .i_adv (w_adv),
                .i_a   (w_a[i][j]),
                .i_b   (w_b[i][j]),
                .o_a   (w_a[i][j+1]),
                .o_b   (w_b[i+1][j]),
                .o_acc (w_acc[i][j])
            );
            assign bus.c_flat[c_idx(i, j, N)*ACC_W +: ACC_W] = w_acc[i][j];
        end
    end
endmodule

// File: tb/tb_systolic_matmul_engine.sv
// tb_systolic_matmul_engine: directed scenarios for the 3x3 engine, honours SYSTOLIC_SIGNED_EN.
module tb_systolic_matmul_engine;
    localparam int N = 3, DW = 32, AW = 64, KM = 255, KW = 8;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    systolic_if #(.N(N), .DATA_W(DW), .ACC_W(AW), .KW(KW)) bus ();
    systolic_matmul_engine #(.N(N), .DATA_W(DW), .ACC_W(AW), .K_MAX(KM)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );
    int errors = 0, checks = 0;
    logic [DW-1:0] a_beat [KM][N];
    logic [DW-1:0] b_beat [KM][N];
    logic [AW-1:0] c_t1 [N][N] = '{'{64'd30, 64'd24, 64'd18}, '{64'd84, 64'd69, 64'd54}, '{64'd138, 64'd114, 64'd90}};
    logic [AW-1:0] c_a  [N][N] = '{'{64'd1, 64'd2, 64'd3}, '{64'd4, 64'd5, 64'd6}, '{64'd7, 64'd8, 64'd9}};
    function automatic logic [AW-1:0] c_get(input int i, input int j);
        return bus.c_flat[(i*N+j)*AW +: AW];
    endfunction
    task automatic set_ab(input bit ident);
        for (int k = 0; k < N; k++)
            for (int i = 0; i < N; i++) begin
                a_beat[k][i] = DW'(3 * i + k + 1);
                b_beat[k][i] = ident ? DW'(k == i) : DW'(9 - (3 * k + i));
            end
    endtask
    task automatic start_op(input int k);
        bus.k_len = KW'(k);
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask
    task automatic feed(input int k, input int gap, output int nr);
        nr = 0;
        for (int t = 0; t < k; t++) begin
            for (int g = 0; g < (t == 0 ? 0 : gap); g++) begin
                bus.in_valid = 1'b0;
                @(posedge clk); #1;
                if (bus.in_ready !== 1'b1) nr++;
            end
            for (int i = 0; i < N; i++) begin
                bus.a_vec[i*DW +: DW] = a_beat[t][i];
                bus.b_vec[i*DW +: DW] = b_beat[t][i];
            end
            if (bus.in_ready !== 1'b1) nr++;
            bus.in_valid = 1'b1;
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
    endtask
    task automatic wait_res(output int n);
        n = 0;
        while (bus.res_valid !== 1'b1 && n < 600) begin
            @(posedge clk); #1;
            n++;
        end
    endtask
    task automatic consume();
        bus.res_ready = 1'b1;
        @(posedge clk); #1;
        bus.res_ready = 1'b0;
    endtask
    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        checks += 4;
        if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL reset in_ready got=%b exp=0", bus.in_ready); end
        if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL reset res_valid got=%b exp=0", bus.res_valid); end
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset busy got=%b exp=0", bus.busy); end
        if (bus.c_flat !== '0) begin errors++; $display("FAIL reset c_flat got=%h exp=0", bus.c_flat); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask
    task automatic test_basic();
        int nr, n;
        set_ab(1'b0);
        start_op(3);
        checks += 2;
        if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL basic in_ready got=%b exp=1", bus.in_ready); end
        if (bus.busy !== 1'b1) begin errors++; $display("FAIL basic busy got=%b exp=1", bus.busy); end
        feed(3, 0, nr);
        checks += 2;
        if (nr !== 0) begin errors++; $display("FAIL basic not_ready_beats got=%0d exp=0", nr); end
        if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL basic early_res_valid got=%b exp=0", bus.res_valid); end
        wait_res(n);
        checks++;
        if (n !== 4) begin errors++; $display("FAIL basic latency_edges_after_last_beat got=%0d exp=4", n); end
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                checks++;
                if (c_get(i, j) !== c_t1[i][j]) begin errors++; $display("FAIL basic C[%0d][%0d] got=%0d exp=%0d", i, j, c_get(i, j), c_t1[i][j]); end
            end
        @(posedge clk); #1;
        checks += 2;
        if (bus.res_valid !== 1'b1) begin errors++; $display("FAIL basic res_valid_hold got=%b exp=1", bus.res_valid); end
        if (c_get(1, 1) !== 64'd69) begin errors++; $display("FAIL basic c_stable got=%0d exp=69", c_get(1, 1)); end
        consume();
        checks += 2;
        if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL basic res_valid_after_ready got=%b exp=0", bus.res_valid); end
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL basic busy_after_ready got=%b exp=0", bus.busy); end
    endtask
    task automatic test_stall();
        int nr, n;
        set_ab(1'b0);
        start_op(3);
        feed(3, 2, nr);
        checks += 2;
        if (nr !== 0) begin errors++; $display("FAIL stall in_ready_low_cycles got=%0d exp=0", nr); end
        wait_res(n);
        if (n !== 4) begin errors++; $display("FAIL stall latency got=%0d exp=4", n); end
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                checks++;
                if (c_get(i, j) !== c_t1[i][j]) begin errors++; $display("FAIL stall C[%0d][%0d] got=%0d exp=%0d", i, j, c_get(i, j), c_t1[i][j]); end
            end
        consume();
    endtask
    task automatic test_back_to_back();
        int nr, n;
        set_ab(1'b0);
        start_op(3);
        feed(3, 0, nr);
        wait_res(n);
        consume();
        set_ab(1'b1);
        start_op(3);
        bus.k_len = '0;
        bus.start = 1'b1;
        feed(3, 0, nr);
        bus.start = 1'b0;
        wait_res(n);
        checks++;
        if (n !== 4) begin errors++; $display("FAIL b2b latency got=%0d exp=4", n); end
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                checks++;
                if (c_get(i, j) !== c_a[i][j]) begin errors++; $display("FAIL b2b C[%0d][%0d] got=%0d exp=%0d", i, j, c_get(i, j), c_a[i][j]); end
            end
        bus.start = 1'b1;
        bus.res_ready = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.res_ready = 1'b0;
        checks += 2;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL b2b busy_after_done got=%b exp=0", bus.busy); end
        if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL b2b start_in_done_ignored in_ready got=%b exp=0", bus.in_ready); end
        @(posedge clk); #1;
        checks += 2;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL b2b idle_stays got=%b exp=0", bus.busy); end
        if (c_get(2, 2) !== 64'd9) begin errors++; $display("FAIL b2b c_kept_in_idle got=%0d exp=9", c_get(2, 2)); end
    endtask
    task automatic test_k_bounds();
        int nr, n;
        logic [AW-1:0] exp_max;
`ifdef SYSTOLIC_SIGNED_EN
        exp_max = 64'd255;
`else
        exp_max = 64'hFFFF_FE02_0000_00FF;
`endif
        start_op(0);
        checks += 3;
        if (bus.res_valid !== 1'b1) begin errors++; $display("FAIL k0 res_valid got=%b exp=1", bus.res_valid); end
        if (bus.busy !== 1'b1) begin errors++; $display("FAIL k0 busy got=%b exp=1", bus.busy); end
        if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL k0 in_ready got=%b exp=0", bus.in_ready); end
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                checks++;
                if (c_get(i, j) !== '0) begin errors++; $display("FAIL k0 C[%0d][%0d] got=%0d exp=0", i, j, c_get(i, j)); end
            end
        consume();
        for (int k = 0; k < KM; k++)
            for (int i = 0; i < N; i++) begin
                a_beat[k][i] = '1;
                b_beat[k][i] = '1;
            end
        start_op(KM);
        feed(KM, 0, nr);
        wait_res(n);
        checks++;
        if (n !== 4) begin errors++; $display("FAIL kmax latency got=%0d exp=4", n); end
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                checks++;
                if (c_get(i, j) !== exp_max) begin errors++; $display("FAIL kmax C[%0d][%0d] got=%h exp=%h", i, j, c_get(i, j), exp_max); end
            end
        consume();
    endtask
    task automatic test_reset_mid();
        int nr, n;
        set_ab(1'b0);
        start_op(3);
        feed(3, 0, nr);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        checks += 4;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL rstmid busy got=%b exp=0", bus.busy); end
        if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL rstmid res_valid got=%b exp=0", bus.res_valid); end
        if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL rstmid in_ready got=%b exp=0", bus.in_ready); end
        if (bus.c_flat !== '0) begin errors++; $display("FAIL rstmid c_flat got=%h exp=0", bus.c_flat); end
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        start_op(3);
        feed(3, 0, nr);
        wait_res(n);
        checks++;
        if (n !== 4) begin errors++; $display("FAIL rstmid latency got=%0d exp=4", n); end
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                checks++;
                if (c_get(i, j) !== c_t1[i][j]) begin errors++; $display("FAIL rstmid C[%0d][%0d] got=%0d exp=%0d", i, j, c_get(i, j), c_t1[i][j]); end
            end
        consume();
    endtask
    task automatic test_signed();
        int nr, n;
        logic [AW-1:0] exp_c;
`ifdef SYSTOLIC_SIGNED_EN
        exp_c = 64'hFFFF_FFFF_FFFF_FFEE;
`else
        exp_c = 64'h0000_0008_FFFF_FFEE;
`endif
        for (int k = 0; k < N; k++)
            for (int i = 0; i < N; i++) begin
                a_beat[k][i] = 32'hFFFF_FFFE;
                b_beat[k][i] = 32'd3;
            end
        start_op(3);
        feed(3, 0, nr);
        wait_res(n);
        checks++;
        if (n !== 4) begin errors++; $display("FAIL signed latency got=%0d exp=4", n); end
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                checks++;
                if (c_get(i, j) !== exp_c) begin errors++; $display("FAIL signed C[%0d][%0d] got=%h exp=%h", i, j, c_get(i, j), exp_c); end
            end
        consume();
    endtask
    initial begin
        bus.start = 1'b0;
        bus.k_len = '0;
        bus.in_valid = 1'b0;
        bus.a_vec = '0;
        bus.b_vec = '0;
        bus.res_ready = 1'b0;
        test_reset();
        test_basic();
        test_stall();
        test_back_to_back();
        test_k_bounds();
        test_reset_mid();
        test_signed();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
